// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: scheduler state encoding, default word width/rounds and
// the derived S-table size used by the cipher and key-expansion blocks.
package rc5_pkg;

  localparam int unsigned DEFAULT_W = 32;
  localparam int unsigned DEFAULT_R = 12;
  localparam int unsigned T         = 2 * (DEFAULT_R + 1);
  localparam int unsigned T_LENGTH  = $clog2(T);

  typedef enum logic [2:0] {
    StIdle,
    StKeyExp,
    StKeyDrop,
    StWaitBlk,
    StCipher,
    StCDrop,
    StOutHold
  } sched_state_e;

endpackage

// File: rtl/rc5_sched_wdog.sv
// Watchdog for the rc5_sched long-running states: counts cycles while i_run is high
// and flags expiry on the last allowed cycle.
module rc5_sched_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] r_cnt;

  // Guarded states are never adjacent, so clearing whenever idle equals clearing on entry.
  always_ff @(posedge clk) begin
    if (!rst || !i_run) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rc5_sched.sv
// RC5 sequencing controller: key expansion once per key load, then one block at a time
// through the cipher core. Optional watchdog enabled by defining RC5_SCHED_WDOG_EN.
module rc5_sched
  import rc5_pkg::*;
#(
  parameter int unsigned W              = DEFAULT_W,
  parameter int unsigned R              = DEFAULT_R,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iKey_load,
  output logic         oKey_ready,
  output logic         oKE_start,
  input  logic         iKE_done,
  output logic         oSel_ke,
  input  logic         iIn_valid,
  output logic         oIn_ready,
  input  logic [W-1:0] iIn_A,
  input  logic [W-1:0] iIn_B,
  output logic         oC_start,
  output logic [W-1:0] oC_A,
  output logic [W-1:0] oC_B,
  input  logic         iC_done,
  input  logic [W-1:0] iC_A,
  input  logic [W-1:0] iC_B,
  output logic         oOut_valid,
  input  logic         iOut_ready,
  output logic [W-1:0] oOut_A,
  output logic [W-1:0] oOut_B,
  output logic         oBusy,
  output logic         oError
);

  if (!(W == 16 || W == 32 || W == 64)) begin : g_bad_w
    $error("rc5_sched: W must be 16, 32 or 64");
  end
  if (R == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("rc5_sched: R must be nonzero and TIMEOUT_CYCLES at least 2");
  end

  sched_state_e r_state;
  logic         r_pend;
  logic         r_in_ready;
  logic         r_key_ready;
  logic         r_ke_start;
  logic         r_sel_ke;
  logic         r_c_start;
  logic         r_out_valid;
  logic         r_error;
  logic [W-1:0] r_c_a, r_c_b;
  logic [W-1:0] r_out_a, r_out_b;

  logic w_in_ready, w_in_hs, w_out_hs, w_key_req, w_go_ke, w_timeout;

  // A pending or same-cycle key load always beats a block handshake.
  assign w_key_req  = iKey_load || r_pend;
  assign w_in_ready = r_in_ready && !w_key_req;
  assign w_in_hs    = iIn_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && iOut_ready;
  assign w_go_ke    = ((r_state == StIdle) && iKey_load) ||
                      ((r_state == StWaitBlk) && w_key_req) ||
                      (w_out_hs && w_key_req);

`ifdef RC5_SCHED_WDOG_EN
  logic w_run, w_expired;

  assign w_run = (r_state == StKeyExp) || (r_state == StCipher);

  rc5_sched_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .o_expired(w_expired)
  );

  assign w_timeout = w_expired &&
                     !((r_state == StKeyExp) && iKE_done) &&
                     !((r_state == StCipher) && iC_done);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_pend      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_key_ready <= 1'b0;
      r_ke_start  <= 1'b0;
      r_sel_ke    <= 1'b1;
      r_c_start   <= 1'b0;
      r_out_valid <= 1'b0;
      r_error     <= 1'b0;
      r_c_a       <= '0;
      r_c_b       <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
    end else if (w_timeout) begin
      r_state     <= StIdle;
      r_error     <= 1'b1;
      r_pend      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_key_ready <= 1'b0;
      r_ke_start  <= 1'b0;
      r_sel_ke    <= 1'b1;
      r_c_start   <= 1'b0;
    end else begin
      if (iKey_load) begin
        r_pend <= 1'b1;
      end
      if (w_go_ke) begin
        r_state     <= StKeyExp;
        r_pend      <= 1'b0;
        r_in_ready  <= 1'b0;
        r_key_ready <= 1'b0;
        r_ke_start  <= 1'b1;
        r_sel_ke    <= 1'b1;
      end
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        if (!w_key_req) begin
          r_state    <= StWaitBlk;
          r_in_ready <= 1'b1;
        end
      end
      unique case (r_state)
        StIdle: ;
        StKeyExp: begin
          if (iKE_done) begin
            r_ke_start <= 1'b0;
            r_state    <= StKeyDrop;
          end
        end
        StKeyDrop: begin
          r_key_ready <= 1'b1;
          r_sel_ke    <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StWaitBlk;
        end
        StWaitBlk: begin
          if (w_in_hs) begin
            r_c_a      <= iIn_A;
            r_c_b      <= iIn_B;
            r_in_ready <= 1'b0;
            r_c_start  <= 1'b1;
            r_state    <= StCipher;
          end
        end
        StCipher: begin
          if (iC_done) begin
            r_out_a     <= iC_A;
            r_out_b     <= iC_B;
            r_out_valid <= 1'b1;
            r_c_start   <= 1'b0;
            r_state     <= StCDrop;
          end
        end
        StCDrop: begin
          if (!w_out_hs) begin
            r_state <= StOutHold;
          end
        end
        StOutHold: ;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oKey_ready = r_key_ready;
  assign oKE_start  = r_ke_start;
  assign oSel_ke    = r_sel_ke;
  assign oIn_ready  = w_in_ready;
  assign oC_start   = r_c_start;
  assign oC_A       = r_c_a;
  assign oC_B       = r_c_b;
  assign oOut_valid = r_out_valid;
  assign oOut_A     = r_out_a;
  assign oOut_B     = r_out_b;
  assign oBusy      = (r_state != StIdle) && (r_state != StWaitBlk);
  assign oError     = r_error;

endmodule

// File: tb/tb_rc5_sched.sv
// Directed bench for rc5_sched with stubbed key-expansion and cipher cores.
module tb_rc5_sched;

  localparam int unsigned W = 32;
`ifdef RC5_SCHED_WDOG_EN
  localparam int KeCycles = 8;
`else
  localparam int KeCycles = 40;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         iKey_load = 1'b0, iKE_done = 1'b0, iIn_valid = 1'b0;
  logic         iC_done = 1'b0, iOut_ready = 1'b0;
  logic [W-1:0] iIn_A = '0, iIn_B = '0, iC_A = '0, iC_B = '0;
  logic         oKey_ready, oKE_start, oSel_ke, oIn_ready, oC_start, oOut_valid;
  logic         oBusy, oError;
  logic [W-1:0] oC_A, oC_B, oOut_A, oOut_B;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rc5_sched #(
    .W             (W),
    .R             (12),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iKey_load (iKey_load),
    .oKey_ready(oKey_ready),
    .oKE_start (oKE_start),
    .iKE_done  (iKE_done),
    .oSel_ke   (oSel_ke),
    .iIn_valid (iIn_valid),
    .oIn_ready (oIn_ready),
    .iIn_A     (iIn_A),
    .iIn_B     (iIn_B),
    .oC_start  (oC_start),
    .oC_A      (oC_A),
    .oC_B      (oC_B),
    .iC_done   (iC_done),
    .iC_A      (iC_A),
    .iC_B      (iC_B),
    .oOut_valid(oOut_valid),
    .iOut_ready(iOut_ready),
    .oOut_A    (oOut_A),
    .oOut_B    (oOut_B),
    .oBusy     (oBusy),
    .oError    (oError)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called right after the edge that entered KEY_EXP; leaves the FSM in WAIT_BLK.
  task automatic run_key(input int n);
    for (int i = 0; i < n; i++) begin
      chk("ke_start_high", 64'(oKE_start), 64'd1);
      chk("ke_sel_high", 64'(oSel_ke), 64'd1);
      if (i == n - 1) iKE_done = 1'b1;
      step();
    end
    chk("ke_drop_start", 64'(oKE_start), 64'd0);
    chk("ke_drop_keyrdy", 64'(oKey_ready), 64'd0);
    chk("ke_drop_sel", 64'(oSel_ke), 64'd1);
    iKE_done = 1'b0;
    step();
    chk("key_ready", 64'(oKey_ready), 64'd1);
    chk("sel_cipher", 64'(oSel_ke), 64'd0);
    chk("wait_busy", 64'(oBusy), 64'd0);
  endtask

  initial begin
    iIn_valid = 1'b1;
    step(); step(); step();
    chk("rst_sel", 64'(oSel_ke), 64'd1);
    chk("rst_keyrdy", 64'(oKey_ready), 64'd0);
    chk("rst_ke_start", 64'(oKE_start), 64'd0);
    chk("rst_c_start", 64'(oC_start), 64'd0);
    chk("rst_out_valid", 64'(oOut_valid), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_error", 64'(oError), 64'd0);
    chk("rst_c_a", 64'(oC_A), 64'd0);
    chk("rst_out_b", 64'(oOut_B), 64'd0);

    rst = 1'b1;
    step();
    chk("idle_no_accept", 64'(oIn_ready), 64'd0);
    iIn_valid = 1'b0;
    iKey_load = 1'b1;
    step();
    iKey_load = 1'b0;
    chk("ke_busy", 64'(oBusy), 64'd1);
    run_key(KeCycles);
    chk("wait_in_ready", 64'(oIn_ready), 64'd1);

    // Block 1 (zero key / zero plaintext reference vector from the stub core)
    iIn_valid = 1'b1;
    step();
    chk("c1_start", 64'(oC_start), 64'd1);
    chk("c1_in_ready", 64'(oIn_ready), 64'd0);
    chk("c1_busy", 64'(oBusy), 64'd1);
    iIn_A = 32'h0123_4567;
    iIn_B = 32'h89AB_CDEF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("c1_start_hold", 64'(oC_start), 64'd1);
      chk("c1_a_stable", 64'(oC_A), 64'd0);
    end
    iC_done = 1'b1;
    iC_A    = 32'hEEDB_A521;
    iC_B    = 32'h6D8F_4B15;
    step();
    chk("cdrop_start", 64'(oC_start), 64'd0);
    chk("cdrop_valid", 64'(oOut_valid), 64'd1);
    chk("out1_a", 64'(oOut_A), 64'hEEDB_A521);
    chk("out1_b", 64'(oOut_B), 64'h6D8F_4B15);
    iC_done = 1'b0;
    iC_A    = 32'hDEAD_BEEF;
    iC_B    = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 64'(oOut_valid), 64'd1);
      chk("hold_a", 64'(oOut_A), 64'hEEDB_A521);
      chk("hold_in_ready", 64'(oIn_ready), 64'd0);
    end
    iOut_ready = 1'b1;
    step();
    chk("ohs_valid_clr", 64'(oOut_valid), 64'd0);
    chk("ohs_in_ready", 64'(oIn_ready), 64'd1);
    iOut_ready = 1'b0;
    step();
    chk("c2_start", 64'(oC_start), 64'd1);
    chk("c2_a", 64'(oC_A), 64'h0123_4567);
    chk("c2_b", 64'(oC_B), 64'h89AB_CDEF);
    iIn_valid = 1'b0;

    // Key load during block 2: block finishes, then key expansion restarts
    step();
    iKey_load = 1'b1;
    step();
    iKey_load = 1'b0;
    chk("pend_keyrdy", 64'(oKey_ready), 64'd1);
    chk("pend_c_start", 64'(oC_start), 64'd1);
    iC_done = 1'b1;
    iC_A    = 32'h1111_2222;
    iC_B    = 32'h3333_4444;
    step();
    iC_done   = 1'b0;
    iIn_valid = 1'b1;
    iIn_A     = 32'hA5A5_5A5A;
    iIn_B     = 32'h0F0F_F0F0;
    step();
    chk("out2_a", 64'(oOut_A), 64'h1111_2222);
    chk("out2_b", 64'(oOut_B), 64'h3333_4444);
    iOut_ready = 1'b1;
    step();
    iOut_ready = 1'b0;
    chk("rekey_start", 64'(oKE_start), 64'd1);
    chk("rekey_keyrdy", 64'(oKey_ready), 64'd0);
    chk("rekey_in_ready", 64'(oIn_ready), 64'd0);
    chk("rekey_valid", 64'(oOut_valid), 64'd0);
    run_key(3);
    chk("rekey_wait_ready", 64'(oIn_ready), 64'd1);

    // Key load collides with an input handshake
    iKey_load = 1'b1;
    #1;
    chk("coll_in_ready", 64'(oIn_ready), 64'd0);
    step();
    iKey_load = 1'b0;
    chk("coll_no_accept", 64'(oC_start), 64'd0);
    chk("coll_keyrdy", 64'(oKey_ready), 64'd0);
    run_key(3);
    step();
    chk("c3_a", 64'(oC_A), 64'hA5A5_5A5A);
    iIn_valid = 1'b0;

    // Reset mid-cipher
    step();
    rst = 1'b0;
    step();
    chk("mrst_c_start", 64'(oC_start), 64'd0);
    chk("mrst_valid", 64'(oOut_valid), 64'd0);
    chk("mrst_keyrdy", 64'(oKey_ready), 64'd0);
    chk("mrst_sel", 64'(oSel_ke), 64'd1);
    chk("mrst_busy", 64'(oBusy), 64'd0);
    rst = 1'b1;
    step();

`ifdef RC5_SCHED_WDOG_EN
    iKey_load = 1'b1;
    step();
    iKey_load = 1'b0;
    run_key(KeCycles);
    iIn_valid = 1'b1;
    step();
    iIn_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("wd_no_err", 64'(oError), 64'd0);
      chk("wd_c_start", 64'(oC_start), 64'd1);
      step();
    end
    chk("wd_last_no_err", 64'(oError), 64'd0);
    step();
    chk("wd_error", 64'(oError), 64'd1);
    chk("wd_c_start_low", 64'(oC_start), 64'd0);
    chk("wd_ke_start_low", 64'(oKE_start), 64'd0);
    chk("wd_idle", 64'(oBusy), 64'd0);
    chk("wd_keyrdy", 64'(oKey_ready), 64'd0);
    chk("wd_in_ready", 64'(oIn_ready), 64'd0);
    step();
    chk("wd_sticky", 64'(oError), 64'd1);
`else
    chk("no_wdog_error", 64'(oError), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
